// File: rtl/c16_tap_pkg.sv
// Shared types and constants for the C16 TAP player: FSM states, header layout and length rules.
package c16_tap_pkg;

   typedef enum logic [2:0] {
      HDR,
      FETCH,
      LONG0,
      LONG1,
      LONG2,
      PULSE
   } tap_state_e;

   localparam int TAP_VER_HDR_IDX = 12;
   localparam int LEN_SHORT_MUL   = 8;
   localparam int LEN_ZERO_V0     = 2048;
   localparam int LEN_W           = 24;

   // One-byte records count in units of eight tape ticks.
   function automatic logic [LEN_W-1:0] short_len(input logic [7:0] b);
      return LEN_W'(b) * LEN_W'(LEN_SHORT_MUL);
   endfunction

endpackage

// File: rtl/c16_tap_if.sv
// Byte stream from the TAP downloader into the player: valid/ready handshake.
interface c16_tap_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/c16_tap_fifo.sv
// Small synchronous byte FIFO with first-word fall-through read and a flush that beats push/pop.
module tap_fifo #(
   parameter int FIFO_AW = 4
) (
   input  logic       CLK28,
   input  logic       sreset,
   input  logic       flush,
   input  logic       push,
   input  logic [7:0] wr_data,
   input  logic       pop,
   output logic [7:0] rd_data,
   output logic       full,
   output logic       empty
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               do_push, do_pop;

   assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         do_push  = 1'b0;
         do_pop   = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK28) begin
      if (sreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK28) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/c16_tap_player.sv
// Plays a buffered TAP image onto the C16 cassette read line, one pulse record at a time,
// timed by the tape tick and gated by PLAY and the cassette motor.
module c16_tap_player
   import c16_tap_pkg::*;
#(
   parameter int FIFO_AW = 4,
   parameter int HDR_LEN = 20
) (
   input  logic       CLK28,
   input  logic       sreset,
   input  logic       ce_tap,
   input  logic       restart,
   input  logic       play,
   input  logic       motor_on,
   c16_tap_if.slave   in_bus,
   output logic       cass_read,
   output logic       cass_sense,
   output logic [1:0] tap_version,
   output logic       underrun
);

   localparam int HDR_CW = $clog2(HDR_LEN);

   tap_state_e       state_q, state_d;
   logic [HDR_CW-1:0] hdr_cnt_q, hdr_cnt_d;
   logic [1:0]       ver_q, ver_d;
   logic             underrun_q, underrun_d;
   logic             level_q, level_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;

   logic             run, push, pop, fetch_now, half_wave, low_phase;
   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_rd_data;
   logic [LEN_W-1:0] long_len;

   assign run             = play & motor_on & ~restart;
   assign half_wave       = ver_q[1];
   assign in_bus.in_ready = ~fifo_full;
   assign push            = in_bus.in_valid & ~fifo_full;

   tap_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .CLK28   (CLK28),
      .sreset  (sreset),
      .flush   (restart),
      .push    (push),
      .wr_data (in_bus.in_data),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge CLK28) begin
      if (sreset) begin
         state_q    <= HDR;
         hdr_cnt_q  <= '0;
         ver_q      <= '0;
         underrun_q <= 1'b0;
         level_q    <= 1'b1;
         len_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         hdr_cnt_q  <= hdr_cnt_d;
         ver_q      <= ver_d;
         underrun_q <= underrun_d;
         level_q    <= level_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
      end
   end

   // A finished record fetches its successor in the same cycle so back-to-back ticks lose no unit.
   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      ver_d      = ver_q;
      underrun_d = underrun_q;
      level_d    = level_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      fetch_now  = 1'b0;
      long_len   = '0;
      case (state_q)
         HDR: begin
            if (!fifo_empty) begin
               if (hdr_cnt_q == HDR_CW'(TAP_VER_HDR_IDX)) ver_d = fifo_rd_data[1:0];
               if (hdr_cnt_q == HDR_CW'(HDR_LEN-1)) begin
                  hdr_cnt_d = '0;
                  state_d   = FETCH;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 1'b1;
               end
            end
         end
         FETCH: fetch_now = run;
         LONG0, LONG1: begin
            if (run) begin
               if (fifo_empty) begin
                  underrun_d = 1'b1;
               end else if (state_q == LONG0) begin
                  len_d[7:0] = fifo_rd_data;
                  state_d    = LONG1;
               end else begin
                  len_d[15:8] = fifo_rd_data;
                  state_d     = LONG2;
               end
            end
         end
         LONG2: begin
            if (run) begin
               if (fifo_empty) begin
                  underrun_d = 1'b1;
               end else begin
                  long_len = {fifo_rd_data, len_q[15:0]};
                  if (long_len == '0) long_len = LEN_W'(1);
                  len_d   = long_len;
                  cnt_d   = long_len - 1'b1;
                  state_d = PULSE;
               end
            end
         end
         PULSE: begin
            if (run && ce_tap) begin
               if (cnt_q == '0) begin
                  if (half_wave) level_d = ~level_q;
                  state_d   = FETCH;
                  fetch_now = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = HDR;
      endcase

      if (fetch_now) begin
         if (fifo_empty) begin
            underrun_d = 1'b1;
         end else if (fifo_rd_data != 8'd0) begin
            len_d   = short_len(fifo_rd_data);
            cnt_d   = short_len(fifo_rd_data) - 1'b1;
            state_d = PULSE;
         end else if (ver_q == 2'd0) begin
            len_d   = LEN_W'(LEN_ZERO_V0);
            cnt_d   = LEN_W'(LEN_ZERO_V0) - 1'b1;
            state_d = PULSE;
         end else begin
            len_d   = '0;
            state_d = LONG0;
         end
      end

      if (restart) begin
         state_d    = HDR;
         hdr_cnt_d  = '0;
         ver_d      = '0;
         underrun_d = 1'b0;
         level_d    = 1'b1;
         len_d      = '0;
         cnt_d      = '0;
      end
   end

   // Full-wave records drive low for the first floor(len/2) units; the counter runs len-1 down to 0.
   always_comb begin
      pop = 1'b0;
      case (state_q)
         HDR:                       pop = ~fifo_empty;
         FETCH, LONG0, LONG1, LONG2: pop = run & ~fifo_empty;
         PULSE:                     pop = run & ce_tap & (cnt_q == '0) & ~fifo_empty;
         default:                   pop = 1'b0;
      endcase
      if (restart) pop = 1'b0;
      low_phase   = (state_q == PULSE) & ~half_wave & (cnt_q >= (len_q - (len_q >> 1)));
      cass_read   = level_q & ~low_phase;
      cass_sense  = ~play;
      tap_version = ver_q;
      underrun    = underrun_q;
   end

endmodule
